// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Define MULDIV_SIGNED_EN to give mult/div two's-complement semantics.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
  logic               r_div, r_neg_q, r_neg_r, r_dz;

  logic w_mult, w_div, w_mthi, w_mtlo, w_mfhi, w_mflo, w_legal;
  logic w_ready, w_start, w_last, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum, w_trial, w_diff;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_acc_next, w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem, w_res_hi, w_res_lo;

  assign w_mult  = (funct == 6'b011000) || (funct == 6'b011001);
  assign w_div   = (funct == 6'b011010) || (funct == 6'b011011);
  assign w_mfhi  = (funct == 6'b010000);
  assign w_mthi  = (funct == 6'b010001);
  assign w_mflo  = (funct == 6'b010010);
  assign w_mtlo  = (funct == 6'b010011);
  assign w_legal = w_mult | w_div | w_mfhi | w_mthi | w_mflo | w_mtlo;

`ifdef MULDIV_SIGNED_EN
  assign w_signed = (funct == 6'b011000) || (funct == 6'b011010);
`else
  assign w_signed = 1'b0;
`endif

  assign w_ready = (r_state != S_RUN);
  assign w_start = en && w_ready && (w_mult || w_div);
  assign w_last  = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  assign w_a_neg = w_signed && a[WIDTH-1];
  assign w_b_neg = w_signed && b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_acc[0]}} & r_opnd};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}.
  assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_trial - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_acc_next = r_div ? w_div_next : w_mul_next;
  assign w_prod     = r_neg_q ? -w_mul_next : w_mul_next;
  assign w_quot     = w_div_next[WIDTH-1:0];
  assign w_rem      = w_div_next[2*WIDTH-1:WIDTH];

  // Divide-by-zero needs only the LO override: remainder already equals the dividend.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      w_res_hi = r_neg_r ? -w_rem : w_rem;
      w_res_lo = r_dz ? '1 : (r_neg_q ? -w_quot : w_quot);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_next = w_start ? S_RUN : S_IDLE;
      S_RUN:          if (w_last) w_state_next = S_DONE;
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_div   <= w_div;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= (b == '0);
      r_acc   <= w_div ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
      r_opnd  <= w_div ? w_b_mag : w_a_mag;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_next;
      if (w_last) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end else if (en && w_mthi) begin
      r_hi <= a;
    end else if (en && w_mtlo) begin
      r_lo <= a;
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign illegal = en && !w_legal;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign rdata   = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000, F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010, F_MTLO  = 6'b010011;
`ifdef MULDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic [5:0] funct = '0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, illegal;
  logic [W-1:0] hi, lo, rdata;
  int errors = 0, checks = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .illegal(illegal), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Returns {HI, LO} computed with plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] model(input logic [5:0] f, input logic [W-1:0] x, y);
    longint sx, sy, q, r;
    logic [2*W-1:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = '0;
    if (f == F_MULT || f == F_MULTU) begin
      if (f == F_MULT && SGN) p = sx * sy;
      else                    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    end else if (y == '0) begin
      p = {x, {W{1'b1}}};
    end else if (f == F_DIV && SGN) begin
      q = sx / sy;
      r = sx % sy;
      p = {r[W-1:0], q[W-1:0]};
    end else begin
      p = {x % y, x / y};
    end
    return p;
  endfunction

  task automatic issue(input logic [5:0] f, input logic [W-1:0] x, y);
    @(negedge clk);
    en = 1'b1; funct = f; a = x; b = y;
    @(negedge clk);
    en = 1'b0; funct = '0; a = '0; b = '0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < W + 20) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [5:0]   tf[6] = '{F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIV, F_DIV};
    logic [W-1:0] ta[6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'hFFFFFFFB, 32'h80000000};
    logic [W-1:0] tb[6] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
`ifdef MULDIV_SIGNED_EN
    logic [W-1:0] th[6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h64, 32'hFFFFFFFB, 32'h0};
    logic [W-1:0] tl[6] = '{32'h1, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
`else
    logic [W-1:0] th[6] = '{32'hFFFFFFFE, 32'h4, 32'h1, 32'h64, 32'hFFFFFFFB, 32'h80000000};
    logic [W-1:0] tl[6] = '{32'h1, 32'hFFFFFFF1, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
`endif
    int cyc;
    for (int i = 0; i < 6; i++) begin
      issue(tf[i], ta[i], tb[i]);
      wait_idle(cyc);
      checks++; if (cyc != W) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, cyc, W); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL dir%0d_done got %b want 1", i, done); end
      checks++; if (hi !== th[i]) begin errors++; $display("FAIL dir%0d_hi got %h want %h", i, hi, th[i]); end
      checks++; if (lo !== tl[i]) begin errors++; $display("FAIL dir%0d_lo got %h want %h", i, lo, tl[i]); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
      exp_hi = th[i]; exp_lo = tl[i];
    end
  endtask

  task automatic test_move;
    logic [2*W-1:0] p;
    int cyc;
    @(negedge clk);
    en = 1'b1; funct = F_MTHI; a = 32'h12345678;
    @(negedge clk);
    exp_hi = 32'h12345678;
    funct = F_MFHI; a = '0;
    #1;
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL mthi_hi got %h want %h", hi, exp_hi); end
    checks++; if (rdata !== exp_hi) begin errors++; $display("FAIL mfhi_rdata got %h want %h", rdata, exp_hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags got busy=%b done=%b want 0 0", busy, done); end
    en = 1'b0;
    p = model(F_MULTU, 32'hABCD, 32'h1234);
    issue(F_MULTU, 32'hABCD, 32'h1234);
    repeat (3) @(negedge clk);
    en = 1'b1; funct = F_MTLO; a = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL mtlo_busy_lo got %h want %h", lo, exp_lo); end
    funct = 6'b111111;
    #1;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_busy got %b want 1", illegal); end
    @(negedge clk);
    en = 1'b0; funct = '0; a = '0;
    wait_idle(cyc);
    {exp_hi, exp_lo} = p;
    checks++; if (lo !== exp_lo || hi !== exp_hi) begin errors++; $display("FAIL busy_ignore_result got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] p;
    int cyc;
    issue(F_MULTU, 32'h00010001, 32'h00020003);
    wait_idle(cyc);
    p = model(F_MULTU, 32'h00010001, 32'h00020003);
    {exp_hi, exp_lo} = p;
    en = 1'b1; funct = F_MFLO;
    #1;
    checks++; if (rdata !== exp_lo) begin errors++; $display("FAIL mflo_done_rdata got %h want %h", rdata, exp_lo); end
    funct = F_DIVU; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    en = 1'b0; funct = '0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    wait_idle(cyc);
    {exp_hi, exp_lo} = model(F_DIVU, 32'd1000, 32'd7);
    checks++; if (cyc != W || hi !== exp_hi || lo !== exp_lo) begin errors++; $display("FAIL b2b_divu got cyc=%0d %h_%h want %0d %h_%h", cyc, hi, lo, W, exp_hi, exp_lo); end
    en = 1'b1; funct = F_MTLO; a = 32'hCAFEF00D;
    @(negedge clk);
    en = 1'b0; funct = '0;
    exp_lo = 32'hCAFEF00D;
    checks++; if (lo !== exp_lo || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_mtlo got lo=%h busy=%b done=%b want %h 0 0", lo, busy, done, exp_lo); end
  endtask

  task automatic test_illegal;
    logic [5:0] f;
    bit legal;
    for (int i = 0; i < 12; i++) begin
      f = 6'($urandom);
      legal = (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU ||
               f == F_MFHI || f == F_MTHI || f == F_MFLO || f == F_MTLO);
      @(negedge clk);
      en = 1'b1; funct = f; a = 32'h5A5A5A5A; b = 32'h3;
      #1;
      checks++; if (illegal !== !legal) begin errors++; $display("FAIL illegal_%02h got %b want %b", f, illegal, !legal); end
      if (legal) en = 1'b0;
      @(negedge clk);
      en = 1'b0;
      checks++; if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0) begin errors++; $display("FAIL illegal_nochange_%02h got %h_%h busy=%b want %h_%h 0", f, hi, lo, busy, exp_hi, exp_lo); end
    end
    funct = 6'b111111;
    #1;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_no_en got %b want 0", illegal); end
    funct = '0;
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit saw_done;
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL rst_mid_hilo got %h_%h want 0_0", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got busy=%b done=%b want 0 0", busy, done); end
    @(negedge clk); reset = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
    checks++; if (saw_done) begin errors++; $display("FAIL rst_mid_no_done got 1 want 0"); end
    issue(F_MULTU, 32'd6, 32'd7);
    wait_idle(cyc);
    exp_hi = '0; exp_lo = 32'd42;
    checks++; if (lo !== exp_lo || hi !== exp_hi) begin errors++; $display("FAIL rst_mid_next got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_random;
    logic [5:0] ops[6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
    logic [5:0] f;
    logic [W-1:0] x, y;
    int cyc, k;
    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(5)];
      x = $urandom; y = $urandom;
      k = $urandom_range(9);
      if (k == 0) y = '0;
      else if (k == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      else if (k == 2) y = y >> $urandom_range(31);
      else if (k == 3) x = x >> $urandom_range(31);
      if (f == F_MTHI || f == F_MTLO) begin
        issue(f, x, y);
        if (f == F_MTHI) exp_hi = x; else exp_lo = x;
        checks++; if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_move got %h_%h busy=%b done=%b want %h_%h", i, hi, lo, busy, done, exp_hi, exp_lo);
        end
      end else begin
        issue(f, x, y);
        wait_idle(cyc);
        {exp_hi, exp_lo} = model(f, x, y);
        checks++; if (cyc != W || done !== 1'b1) begin errors++; $display("FAIL rnd%0d_timing got cyc=%0d done=%b want %0d 1", i, cyc, done, W); end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin
          errors++; $display("FAIL rnd%0d_f%02h %h,%h got %h_%h want %h_%h", i, f, x, y, hi, lo, exp_hi, exp_lo);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_move;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multiply/divide unit with HI/LO registers for the MIPS datapath, sitting beside the ALU in the execute stage. It decodes the R-type `funct` field for the HI/LO group: `mult`, `multu`, `div`, `divu`, `mfhi`, `mflo`, `mthi` and `mtlo`. Multiply and divide run iteratively, one bit per cycle. The controller stalls the pipeline on `busy`.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be ≥ 4 and even.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  request valid; qualifies `funct`, `a` and `b`.
- `funct`  in  6  R-type function field.
- `a`  in  WIDTH  rs operand (multiplicand or dividend; source for `mthi`/`mtlo`).
- `b`  in  WIDTH  rt operand (multiplier or divisor).
- `busy`  out  1  iteration in progress; requests are ignored.
- `done`  out  1  one-cycle pulse; HI/LO were updated at the preceding edge.
- `illegal`  out  1  combinational: `en` high with a `funct` outside the HI/LO group.
- `hi`, `lo`  out  WIDTH  architectural HI and LO registers.
- `rdata`  out  WIDTH  combinational: `hi` when `funct`=010000 (mfhi), `lo` when `funct`=010010 (mflo), otherwise 0.

## Operation
- **Decode:**
  - 011000 mult
  - 011001 multu
  - 011010 div
  - 011011 divu
  - 010000 mfhi
  - 010010 mflo
  - 010001 mthi
  - 010011 mtlo
- **FSM states:** IDLE, RUN, DONE.
  - IDLE/DONE → RUN on `en` and a mult/div code.
  - RUN → DONE when the iteration counter reaches WIDTH−1.
  - DONE → IDLE otherwise.
- **Iteration counter:** `$clog2(WIDTH)` bits. Cleared on acceptance, increments each RUN cycle.
- **Operand capture at acceptance:**
  - Signed ops latch the magnitudes of `a` and `b` plus the sign flags.
  - Unsigned ops latch the operands raw.
- **Multiply:** shift-add into a 2·WIDTH accumulator. The final edge applies the sign and writes `{hi,lo}` = product.
- **Divide:** restoring division, one quotient bit per cycle.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
- **Divide by zero** (b=0): LO = all ones, HI = `a`. The full WIDTH cycles still elapse.
- **Signed overflow:** most-negative ÷ −1 gives LO = `a`, HI = 0.
- **mthi/mtlo:** in IDLE or DONE with `en`, write `a` to HI or LO at the next edge. No busy period and no `done` pulse.
- **mfhi/mflo:** read-only, with no state change. `rdata` reflects the current HI/LO, so a read in the DONE cycle already sees the new result.
- **Requests while busy:** all ignored. HI/LO are held and `illegal` is still computed.
- **Illegal or unrecognised `funct` with `en`:** no state change.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE, counter=0. Reset is effective immediately, asynchronously.
- **Latency:** a request accepted at edge E0 puts `busy` high from E0 to E_WIDTH. HI/LO are written at E_WIDTH. `done`=1 and `busy`=0 in the cycle after E_WIDTH. A result is therefore available WIDTH cycles after acceptance.
- **Back-to-back:** a new mult/div or `mthi`/`mtlo` is accepted in the DONE cycle with no bubble.
- **Reset mid-operation:** the operation is aborted. HI/LO return to 0, and no `done` pulse follows.
- **`rdata` and `illegal`:** purely combinational, with no registered delay.

## Configuration
- **`MULDIV_SIGNED_EN` defined:** `mult` and `div` perform two's-complement arithmetic as described above.
- **Not defined:**
  - `mult` and `div` are executed exactly as `multu` and `divu`; sign-correction logic is absent.
  - The signed-overflow rule does not apply.
  - The signed funct codes are still legal (`illegal`=0).

## Test plan
- **multu, 0xFFFFFFFF × 0xFFFFFFFF:** `busy` for 32 cycles, then `done` pulse; `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **mult, −3 × 5, with `MULDIV_SIGNED_EN`:** `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Without the macro: `hi`=0x00000004, `lo`=0xFFFFFFF1.
- **div −7 ÷ 2 (signed):** `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **divu 100 ÷ 0:** after 32 cycles, `lo`=0xFFFFFFFF, `hi`=0x00000064.
- **mthi 0x12345678, then mfhi:** `hi`=0x12345678 one edge later and `rdata`=0x12345678, with no `busy` or `done`. An mtlo issued during a later `busy` window leaves `lo` unchanged.
- **Reset at RUN cycle 10 of a multu:** `hi`=`lo`=0 and `busy`=0 immediately, with no `done` pulse. The next multu, 6 × 7, yields `lo`=42.
